// File: rtl/machine_timer_pkg.sv
// Shared constants and helpers for the machine timer: register offsets, irq bit positions,
// register-select decode and byte-lane merge.
package machine_timer_pkg;

  // Byte offsets of the memory-mapped registers.
  localparam logic [4:0] MTIME_LO    = 5'h00;
  localparam logic [4:0] MTIME_HI    = 5'h04;
  localparam logic [4:0] MTIMECMP_LO = 5'h08;
  localparam logic [4:0] MTIMECMP_HI = 5'h0C;
  localparam logic [4:0] MSIP        = 5'h10;

  // mip bit positions, shared with the CSR bank's interrupt codes.
  localparam int unsigned IRQ_MSIP = 3;
  localparam int unsigned IRQ_MTIP = 7;
  localparam int unsigned IRQ_MEIP = 11;

  typedef enum logic [2:0] {
    RegMtimeLo,
    RegMtimeHi,
    RegCmpLo,
    RegCmpHi,
    RegMsip,
    RegNone
  } reg_sel_e;

  // Decode a word index (byte offset bits [4:2]) into a register select.
  function automatic reg_sel_e decode_reg(logic [2:0] word);
    reg_sel_e sel;
    sel = RegNone;
    case (word)
      MTIME_LO[4:2]:    sel = RegMtimeLo;
      MTIME_HI[4:2]:    sel = RegMtimeHi;
      MTIMECMP_LO[4:2]: sel = RegCmpLo;
      MTIMECMP_HI[4:2]: sel = RegCmpHi;
      MSIP[4:2]:        sel = RegMsip;
      default:          sel = RegNone;
    endcase
    return sel;
  endfunction

  // Replace the byte lanes selected by be with the corresponding lanes of wdata.
  function automatic logic [31:0] byte_merge(logic [31:0] old, logic [31:0] wdata,
                                             logic [3:0] be);
    logic [31:0] res;
    res = old;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = wdata[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/machine_timer_irq_sync.sv
// Generic multi-flop synchroniser for a level interrupt request, async active-low reset.
module irq_sync #(
  parameter int unsigned DEPTH = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout
);

  logic [DEPTH-1:0] sync_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[DEPTH-2:0], din};
    end
  end

  assign dout = sync_q[DEPTH-1];

endmodule

// File: rtl/machine_timer.sv
// CLINT-style machine timer: 64-bit mtime/mtimecmp, msip bit and synchronised external irq,
// presented as a level interrupt vector using mip bit positions.
module machine_timer
  import machine_timer_pkg::*;
#(
  parameter int unsigned PRESCALE   = 1,
  parameter int unsigned SYNC_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable_i,
  input  logic [3:0]  write_en_i,
  input  logic [4:0]  address_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  input  logic        meip_i,
  output logic [31:0] irq_o
);

  localparam int unsigned CntW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [CntW-1:0] presc_q, presc_d;
  logic            tick;
  logic [63:0]     mtime_q, mtime_d;
  logic [63:0]     mtimecmp_q, mtimecmp_d;
  logic            msip_q, msip_d;
  logic            mtip_q;
  logic [31:0]     rdata_q, rdata_d;
  logic            meip_sync;
  logic            wr, rd;
  reg_sel_e        sel;
  logic            unused_addr_bits;

  assign unused_addr_bits = ^address_i[1:0];

  assign sel = decode_reg(address_i[4:2]);
  assign wr  = enable_i & (|write_en_i);
  assign rd  = enable_i & ~(|write_en_i);

  // Free-running prescaler; bus traffic never disturbs it.
  assign tick    = (presc_q == CntW'(PRESCALE - 1));
  assign presc_d = tick ? '0 : presc_q + 1'b1;

  // A write to either mtime half suppresses the increment for the whole 64-bit value.
  always_comb begin
    mtime_d = mtime_q;
    if (wr && (sel == RegMtimeLo)) begin
      mtime_d[31:0] = byte_merge(mtime_q[31:0], data_i, write_en_i);
    end else if (wr && (sel == RegMtimeHi)) begin
      mtime_d[63:32] = byte_merge(mtime_q[63:32], data_i, write_en_i);
    end else if (tick) begin
      mtime_d = mtime_q + 64'd1;
    end
  end

  always_comb begin
    mtimecmp_d = mtimecmp_q;
    if (wr && (sel == RegCmpLo)) begin
      mtimecmp_d[31:0] = byte_merge(mtimecmp_q[31:0], data_i, write_en_i);
    end else if (wr && (sel == RegCmpHi)) begin
      mtimecmp_d[63:32] = byte_merge(mtimecmp_q[63:32], data_i, write_en_i);
    end
  end

  always_comb begin
    msip_d = msip_q;
    if (wr && (sel == RegMsip) && write_en_i[0]) begin
      msip_d = data_i[0];
    end
  end

  // Read mux samples the pre-update register values.
  always_comb begin
    rdata_d = rdata_q;
    if (rd) begin
      case (sel)
        RegMtimeLo: rdata_d = mtime_q[31:0];
        RegMtimeHi: rdata_d = mtime_q[63:32];
        RegCmpLo:   rdata_d = mtimecmp_q[31:0];
        RegCmpHi:   rdata_d = mtimecmp_q[63:32];
        RegMsip:    rdata_d = {31'b0, msip_q};
        default:    rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc_q    <= '0;
      mtime_q    <= '0;
      mtimecmp_q <= '1;
      msip_q     <= 1'b0;
      mtip_q     <= 1'b0;
      rdata_q    <= '0;
    end else begin
      presc_q    <= presc_d;
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      msip_q     <= msip_d;
      mtip_q     <= (mtime_q >= mtimecmp_q);
      rdata_q    <= rdata_d;
    end
  end

  irq_sync #(
    .DEPTH(SYNC_DEPTH)
  ) u_meip_sync (
    .clk  (clk),
    .reset(reset),
    .din  (meip_i),
    .dout (meip_sync)
  );

  always_comb begin
    irq_o           = '0;
    irq_o[IRQ_MSIP] = msip_q;
    irq_o[IRQ_MTIP] = mtip_q;
    irq_o[IRQ_MEIP] = meip_sync;
  end

  assign data_o = rdata_q;

endmodule

// File: tb/tb_machine_timer.sv
// Bench for machine_timer: two instances (PRESCALE 1 and 4) driven by directed and random bus
// traffic, checked every cycle against a behavioural model of the register map.
module tb_machine_timer;

  localparam int unsigned SD = 2;

  logic        clk;
  logic        reset;
  logic        enable_i;
  logic [3:0]  write_en_i;
  logic [4:0]  address_i;
  logic [31:0] data_i;
  logic        meip_i;
  logic [31:0] data_o, irq_o;
  logic [31:0] data_o4, irq_o4;

  machine_timer #(
    .PRESCALE  (1),
    .SYNC_DEPTH(SD)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enable_i  (enable_i),
    .write_en_i(write_en_i),
    .address_i (address_i),
    .data_i    (data_i),
    .data_o    (data_o),
    .meip_i    (meip_i),
    .irq_o     (irq_o)
  );

  machine_timer #(
    .PRESCALE  (4),
    .SYNC_DEPTH(SD)
  ) dut4 (
    .clk       (clk),
    .reset     (reset),
    .enable_i  (enable_i),
    .write_en_i(write_en_i),
    .address_i (address_i),
    .data_i    (data_i),
    .data_o    (data_o4),
    .meip_i    (meip_i),
    .irq_o     (irq_o4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Behavioural model state, index 0: PRESCALE=1, index 1: PRESCALE=4.
  int unsigned pre [2] = '{1, 4};
  int unsigned m_cnt [2];
  logic [63:0] m_mtime [2];
  logic [63:0] m_cmp;
  logic        m_msip;
  logic        m_mtip [2];
  logic [31:0] m_rdata [2];
  logic        meip_hist [$];
  logic        meip_next;

  task automatic model_reset();
    for (int p = 0; p < 2; p++) begin
      m_cnt[p]   = 0;
      m_mtime[p] = 64'd0;
      m_mtip[p]  = 1'b0;
      m_rdata[p] = 32'd0;
    end
    m_cmp  = {64{1'b1}};
    m_msip = 1'b0;
    meip_hist.delete();
  endtask

  function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] d, logic [3:0] be);
    logic [31:0] mask;
    mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    return (old & ~mask) | (d & mask);
  endfunction

  function automatic logic [31:0] model_read(int p, int word);
    case (word)
      0:       return m_mtime[p][31:0];
      1:       return m_mtime[p][63:32];
      2:       return m_cmp[31:0];
      3:       return m_cmp[63:32];
      4:       return {31'b0, m_msip};
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] exp_irq(int p);
    logic meip_exp;
    meip_exp = (meip_hist.size() >= SD) ? meip_hist[meip_hist.size() - SD] : 1'b0;
    return (32'(m_msip) << 3) | (32'(m_mtip[p]) << 7) | (32'(meip_exp) << 11);
  endfunction

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_step();
    int  word;
    bool_t_dummy: begin end
    word = int'(address_i[4:2]);
    meip_hist.push_back(meip_i);
    for (int p = 0; p < 2; p++) begin
      logic tick_now;
      logic hit_mtime;
      tick_now  = (m_cnt[p] == pre[p] - 1);
      m_cnt[p]  = (m_cnt[p] + 1) % pre[p];
      m_mtip[p] = (m_mtime[p] >= m_cmp);
      hit_mtime = enable_i && (write_en_i != 0) && (word == 0 || word == 1);
      if (enable_i && write_en_i == 0) m_rdata[p] = model_read(p, word);
      if (hit_mtime) begin
        if (word == 0) m_mtime[p][31:0] = merge(m_mtime[p][31:0], data_i, write_en_i);
        else m_mtime[p][63:32] = merge(m_mtime[p][63:32], data_i, write_en_i);
      end else if (tick_now) begin
        m_mtime[p] = m_mtime[p] + 64'd1;
      end
    end
    if (enable_i && write_en_i != 0) begin
      if (word == 2) m_cmp[31:0] = merge(m_cmp[31:0], data_i, write_en_i);
      if (word == 3) m_cmp[63:32] = merge(m_cmp[63:32], data_i, write_en_i);
      if (word == 4 && write_en_i[0]) m_msip = data_i[0];
    end
  endtask

  task automatic step(input logic en, input logic [3:0] we, input logic [4:0] a,
                      input logic [31:0] d);
    @(negedge clk);
    enable_i   = en;
    write_en_i = we;
    address_i  = a;
    data_i     = d;
    meip_i     = meip_next;
    @(posedge clk);
    #1;
    model_step();
    check("rdata_p1", data_o, m_rdata[0]);
    check("irq_p1", irq_o, exp_irq(0));
    check("rdata_p4", data_o4, m_rdata[1]);
    check("irq_p4", irq_o4, exp_irq(1));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 4'h0, 5'h00, 32'h0);
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
    step(1'b1, be, a, d);
  endtask

  task automatic rd(input logic [4:0] a);
    step(1'b1, 4'h0, a, 32'h0);
  endtask

  logic [31:0] rnd_data;
  logic [3:0]  rnd_we;
  int          meip_cnt;
  logic        seen;

  initial begin
    reset      = 1'b0;
    enable_i   = 1'b0;
    write_en_i = 4'h0;
    address_i  = 5'h0;
    data_i     = 32'h0;
    meip_i     = 1'b0;
    meip_next  = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    check("reset_data", data_o, 32'h0);
    check("reset_irq", irq_o, 32'h0);
    check("reset_data4", data_o4, 32'h0);
    check("reset_irq4", irq_o4, 32'h0);
    #1 reset = 1'b1;

    // Free-running count from reset.
    idle(10);
    rd(5'h00);
    check("mtime_after_10", data_o, 32'd10);
    check("mtime4_after_10", data_o4, 32'd2);

    // Compare threshold at 20: irq rises the cycle after mtime reaches 20.
    wr(5'h0C, 32'h0, 4'hF);
    wr(5'h08, 32'd20, 4'hF);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      idle(1);
      seen = irq_o[7];
    end
    check("mtip_rise_seen", 32'(seen), 32'd1);
    rd(5'h00);
    check("mtime_at_mtip", data_o, 32'd21);
    wr(5'h08, 32'hFFFF_FFFF, 4'hF);
    idle(2);
    check("mtip_cleared", 32'(irq_o[7]), 32'd0);

    // 64-bit wrap, then low-to-high carry.
    wr(5'h00, 32'hFFFF_FFFE, 4'hF);
    wr(5'h04, 32'hFFFF_FFFF, 4'hF);
    idle(2);
    rd(5'h04);
    check("wrap_hi", data_o, 32'h0);
    wr(5'h04, 32'h0, 4'hF);
    wr(5'h00, 32'hFFFF_FFFF, 4'hF);
    rd(5'h04);
    rd(5'h04);
    check("carry_hi", data_o, 32'h1);

    // Byte write in a tick cycle leaves other bytes alone and skips the increment.
    wr(5'h00, 32'h1234_5600, 4'hF);
    wr(5'h00, 32'h0000_00AB, 4'b0001);
    rd(5'h00);
    check("byte_write", data_o, 32'h1234_56AB);

    // Software interrupt and synchronised external interrupt.
    wr(5'h10, 32'hFFFF_FFFF, 4'hF);
    check("msip_set", 32'(irq_o[3]), 32'd1);
    rd(5'h10);
    check("msip_read", data_o, 32'h1);
    wr(5'h10, 32'h0, 4'hF);
    check("msip_clr", 32'(irq_o[3]), 32'd0);
    meip_cnt  = 0;
    meip_next = 1'b1;
    for (int i = 0; i < 3; i++) begin
      idle(1);
      if (irq_o[11]) meip_cnt++;
    end
    meip_next = 1'b0;
    for (int i = 0; i < 6; i++) begin
      idle(1);
      if (irq_o[11]) meip_cnt++;
    end
    check("meip_width", 32'(meip_cnt), 32'd3);

    // Asynchronous reset in the middle of a count.
    idle(5);
    #2 reset = 1'b0;
    #1;
    check("midrst_data", data_o, 32'h0);
    check("midrst_irq", irq_o, 32'h0);
    check("midrst_data4", data_o4, 32'h0);
    check("midrst_irq4", irq_o4, 32'h0);
    reset = 1'b1;
    model_reset();
    rd(5'h08);
    check("cmp_after_rst", data_o, 32'hFFFF_FFFF);
    rd(5'h0C);
    check("cmp4_after_rst", data_o4, 32'hFFFF_FFFF);

    // Random traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      case ($urandom_range(0, 3))
        0:       rnd_data = $urandom;
        1:       rnd_data = $urandom_range(0, 64);
        2:       rnd_data = 32'hFFFF_FFFF;
        default: rnd_data = 32'hFFFF_FFFE;
      endcase
      rnd_we = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
      if ($urandom_range(0, 3) == 0) meip_next = ~meip_next;
      step(($urandom_range(0, 9) < 6), rnd_we, 5'($urandom_range(0, 31)), rnd_data);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
